// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver.
//   uart_tx_state_t      : transmitter FSM states
//   UART_DATA_BITS       : data bits per frame
//   uart_cycles_per_bit  : clock cycles per line bit, integer-truncated
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int UART_DATA_BITS = 8;

  function automatic int uart_cycles_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if
// Byte stream handshake into the UART transmitter.
//   data_in   : byte to transmit
//   valid_in  : data_in valid this cycle
//   ready_out : transmitter can accept a byte; transfer on valid && ready
// Modports: master (byte producer), slave (uart_tx).
// ---------------------------------------------------------------------------
interface uart_tx_if;

  logic [uart_pkg::UART_DATA_BITS-1:0] data_in;
  logic                                valid_in;
  logic                                ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);

endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous byte FIFO feeding the transmitter. The read port is
// first-word-fall-through: rd_data shows the oldest entry while !empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
//   clk_in, rst_in : clock, synchronous active-high reset
//   wr_en, wr_data : write port (ignored while full)
//   rd_en, rd_data : read port (ignored while empty)
//   full, empty    : status from the registered pointers
//   count          : number of stored bytes
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      wr_en,
  input  logic [UART_DATA_BITS-1:0] wr_data,
  input  logic                      rd_en,
  output logic [UART_DATA_BITS-1:0] rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [AW:0]               count
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]               wr_ptr;
  logic [AW:0]               rd_ptr;
  logic                      do_wr;
  logic                      do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage holds data only, so it is not reset.
  always_ff @(posedge clk_in) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmitter: bytes enter through a valid/ready handshake into a FIFO
// and are sent as 8N1 frames (start 0, data LSB first, stop 1), back-to-back
// whenever the FIFO still holds data at the end of a stop bit.
// Optional feature macro: UART_TX_PARITY_EN -- when defined, an even parity
// bit (XOR of the data bits) is inserted before the stop bit (8E1).
// Ports:
//   clk_in      : system clock (CLK_FREQ Hz)
//   rst_in      : synchronous active-high reset
//   tx_bus      : uart_tx_if.slave byte handshake (data_in/valid_in/ready_out)
//   uart_tx_out : registered serial line, idle high
//   busy_out    : high while a frame is on the line or bytes are queued
// ---------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 12_000_000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  uart_tx_if.slave   tx_bus,
  output logic       uart_tx_out,
  output logic       busy_out
);

  localparam int CYCLES_PER_BIT = uart_cycles_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int IDX_W          = $clog2(UART_DATA_BITS);
  localparam int FAW            = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  if (CYCLES_PER_BIT < 2) begin : g_cpb_check
    $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
  end

  uart_tx_state_t            state_q;
  uart_tx_state_t            state_n;
  logic [CNT_W-1:0]          bit_cnt_q;
  logic [IDX_W-1:0]          bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      tx_q;
  logic                      busy_q;
  logic                      bit_last;
  logic                      pop;
  logic                      line_bit;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q;
`endif

  logic [UART_DATA_BITS-1:0] fifo_rd_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [FAW:0]              fifo_count;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .wr_en   (tx_bus.valid_in),
    .wr_data (tx_bus.data_in),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign tx_bus.ready_out = !fifo_full;
  assign uart_tx_out      = tx_q;
  assign busy_out         = busy_q;

  assign bit_last = (bit_cnt_q == CNT_LAST);

  // Next state, FIFO pop and the line level for the current bit.
  always_comb begin
    state_n  = state_q;
    pop      = 1'b0;
    line_bit = 1'b1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        line_bit = 1'b0;
        if (bit_last) state_n = DATA;
      end
      DATA: begin
        line_bit = shift_q[0];
        if (bit_last && bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line_bit = parity_q;
        if (bit_last) state_n = STOP;
      end
`endif
      STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (bit_last) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control registers. The line is registered, so it lags the FSM by one
  // cycle; busy is registered the same way to stay aligned with the line.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      tx_q    <= line_bit;
      busy_q  <= (state_q != IDLE) || (fifo_count != '0);
      if (state_q == IDLE || bit_last) bit_cnt_q <= '0;
      else                             bit_cnt_q <= bit_cnt_q + 1'b1;
      if (state_q == DATA) begin
        if (bit_last) bit_idx_q <= bit_idx_q + 1'b1;
      end else begin
        bit_idx_q <= '0;
      end
    end
  end

  // Data registers: loaded on pop, shifted right at the end of each data bit.
  always_ff @(posedge clk_in) begin
    if (pop) begin
      shift_q  <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
      parity_q <= ^fifo_rd_data;
`endif
    end else if (state_q == DATA && bit_last) begin
      shift_q <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx at default parameters. Works with or
// without UART_TX_PARITY_EN defined.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 12_000_000;
  localparam int DEPTH    = 16;
  localparam int CPB      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic clk_in = 1'b0;
  logic rst_in;
  logic uart_tx_out;
  logic busy_out;

  uart_tx_if bus ();

  uart_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .tx_bus      (bus),
    .uart_tx_out (uart_tx_out),
    .busy_out    (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int         n_chk = 0;
  int         n_fail = 0;
  logic       hist[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  bit         last_acc;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: record any accepted byte, then sample the line after the edge.
  task automatic step();
    last_acc = bus.valid_in && bus.ready_out && !rst_in;
    if (last_acc) exp_q.push_back(bus.data_in);
    @(posedge clk_in);
    #1;
    hist.push_back(uart_tx_out);
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input logic par, input int k);
    if (k == 0)      return 1'b0;
    if (k <= 8)      return d[k-1];
    if (k == NB - 1) return 1'b1;
    return par;
  endfunction

  // Reference receiver: scan the recorded line for frames, each bit held
  // exactly CPB cycles, and collect the bytes.
  task automatic decode(output int errs);
    int         i;
    logic [7:0] d;
    logic       b0;
    errs = 0;
    d    = '0;
    rx_q.delete();
    i = 0;
    while (i < hist.size()) begin
      if (hist[i] !== 1'b0) begin
        i++;
        continue;
      end
      if (i + FL > hist.size()) begin
        errs++;
        break;
      end
      for (int b = 0; b < NB; b++) begin
        b0 = hist[i + b*CPB];
        for (int c = 1; c < CPB; c++)
          if (hist[i + b*CPB + c] !== b0) errs++;
        if (b >= 1 && b <= 8) d[b-1] = b0;
`ifdef UART_TX_PARITY_EN
        if (b == 9 && b0 !== ^d) errs++;
`endif
        if (b == NB - 1 && b0 !== 1'b1) errs++;
      end
      rx_q.push_back(d);
      i += FL;
    end
  endtask

  task automatic compare_rx(input string tag);
    int errs;
    decode(errs);
    check({tag, "_framing_errors"}, errs, 0);
    check({tag, "_byte_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int t;
    t = 0;
    while (busy_out !== 1'b0 && t < limit) begin
      step();
      t++;
    end
    check({tag, "_drained"}, busy_out, 0);
  endtask

  task automatic do_reset();
    rst_in       = 1'b1;
    bus.valid_in = 1'b0;
    step();
    step();
    rst_in = 1'b0;
    exp_q.delete();
    hist.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, bad_j, s0, n, low_at, acc_at_low, rise_at;
    logic [7:0] d;
    logic       ex;

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h03, 1'b0};
    vecs[3] = '{8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b0};
    vecs[5] = '{8'h55, 1'b0};
    vecs[6] = '{8'hC3, 1'b0};
    vecs[7] = '{8'h01, 1'b1};

    rst_in       = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    step();
    step();
    check("reset_line", uart_tx_out, 1);
    check("reset_ready", bus.ready_out, 1);
    check("reset_busy", busy_out, 0);
    rst_in = 1'b0;
    step();
    check("idle_line", uart_tx_out, 1);
    check("idle_busy", busy_out, 0);

    // Single frames from idle: exact latency, bit timing and busy fall.
    for (int v = 0; v < 8; v++) begin
      d            = vecs[v].data;
      bad          = 0;
      bad_j        = -1;
      bus.valid_in = 1'b1;
      bus.data_in  = d;
      step();
      bus.valid_in = 1'b0;
      for (int j = 1; j <= FL + 3; j++) begin
        bus.data_in = 8'($urandom);
        step();
        ex = (j >= 2 && j < 2 + FL) ? frame_bit(d, vecs[v].par, (j - 2) / CPB) : 1'b1;
        if (uart_tx_out !== ex) begin
          if (bad == 0) bad_j = j;
          bad++;
        end
        if (j == FL + 1) check($sformatf("frame_%02h_busy_last", d), busy_out, 1);
        if (j == FL + 2) check($sformatf("frame_%02h_busy_fall", d), busy_out, 0);
      end
      if (bad != 0) $display("  frame %02h first wrong line cycle %0d", d, bad_j);
      check($sformatf("frame_%02h_wrong_cycles", d), bad, 0);
    end

    // Back-to-back frames: no idle cycle between stop and next start.
    hist.delete();
    exp_q.delete();
    bus.valid_in = 1'b1;
    bus.data_in  = 8'h00;
    step();
    bus.data_in = 8'hFF;
    step();
    bus.valid_in = 1'b0;
    for (int t = 0; t < 2*FL + 8; t++) step();
    s0 = -1;
    for (int i = 0; i < hist.size(); i++)
      if (s0 < 0 && hist[i] === 1'b0) s0 = i;
    check("b2b_start_latency", s0, 2);
    if (s0 < 0) s0 = 0;
    check("b2b_first_stop", hist[s0 + FL - 1], 1);
    check("b2b_second_start", hist[s0 + FL], 0);
    check("b2b_line_after_160", hist[s0 + 2*FL], 1);
    check("b2b_busy_end", busy_out, 0);
    compare_rx("b2b");

    // Reset during data bit 3 of 0x3C with four more bytes queued.
    hist.delete();
    bus.valid_in = 1'b1;
    bus.data_in  = 8'h3C;
    step();
    bus.data_in = 8'h11; step();
    bus.data_in = 8'h22; step();
    bus.data_in = 8'h33; step();
    bus.data_in = 8'h44; step();
    bus.valid_in = 1'b0;
    while (hist.size() < 2 + 4*CPB + 4) step();
    check("mid_frame_bit3_level", uart_tx_out, 1);
    check("mid_frame_busy", busy_out, 1);
    rst_in = 1'b1;
    step();
    check("rst_mid_line", uart_tx_out, 1);
    check("rst_mid_busy", busy_out, 0);
    check("rst_mid_ready", bus.ready_out, 1);
    rst_in = 1'b0;
    exp_q.delete();
    bad = 0;
    for (int t = 0; t < 2*FL; t++) begin
      step();
      if (uart_tx_out !== 1'b1 || busy_out !== 1'b0) bad++;
    end
    check("rst_mid_quiet_cycles_bad", bad, 0);

    // Backpressure: valid held high from reset with an incrementing byte.
    do_reset();
    bus.valid_in = 1'b1;
    bus.data_in  = 8'h00;
    n          = 0;
    low_at     = -1;
    acc_at_low = -1;
    rise_at    = -1;
    for (int t = 0; t < 3000; t++) begin
      step();
      if (last_acc) begin
        n++;
        bus.data_in = bus.data_in + 8'h01;
      end
      if (n >= 20) bus.valid_in = 1'b0;
      if (low_at < 0 && bus.ready_out === 1'b0) begin
        low_at     = t;
        acc_at_low = n;
      end
      if (low_at >= 0 && rise_at < 0 && bus.ready_out === 1'b1) rise_at = t;
      if (n >= 20 && busy_out === 1'b0) break;
    end
    check("bp_ready_low_cycle", low_at, 16);
    check("bp_accepted_at_full", acc_at_low, 17);
    check("bp_ready_rise_cycle", rise_at, FL + 1);
    check("bp_drained", busy_out, 0);
    compare_rx("bp");

    // Randomised bursts against the reference receiver.
    hist.delete();
    exp_q.delete();
    n = 0;
    for (int t = 0; t < 6000; t++) begin
      bus.valid_in = (n < 30) && ($urandom_range(0, 2) == 0);
      bus.data_in  = 8'($urandom);
      step();
      if (last_acc) n++;
      if (n >= 30 && busy_out === 1'b0) break;
    end
    bus.valid_in = 1'b0;
    check("rand_accepted", n, 30);
    wait_idle("rand", 4000);
    compare_rx("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter paired with the existing `uart_rx` receiver. It sends 8N1 frames (optionally 8E1) on the serial TX pin. Bytes arrive through a valid/ready interface into an internal FIFO, so top-level logic (e.g. an echo path driven by `uart_rx` `valid_out`) can push bursts without stalling. It sits in the top level between user logic and `uart_txd`.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 12_000_000: line rate in baud.
- `FIFO_DEPTH`, 16: byte FIFO depth. Must be a power of two and at least 2.
- `clk_in` input 1: system clock. This is the block's only clock.
- `rst_in` input 1: reset, synchronous and active-high.
- `data_in` input 8: byte to transmit.
- `valid_in` input 1: `data_in` is valid this cycle.
- `ready_out` output 1: FIFO can accept a byte. A transfer happens on `valid_in && ready_out` at the rising edge.
- `uart_tx_out` output 1: serial line, registered, idle high.
- `busy_out` output 1: high while a frame is on the line or the FIFO is non-empty.

## Operation
- `CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE`, integer-truncated. Defaults give 8. An elaboration-time error is raised if it is below 2.
- Bit counter width is `$clog2(CYCLES_PER_BIT)`. It counts 0 up to `CYCLES_PER_BIT-1` and then wraps.
- Frame format: start bit (0), then data bits LSB first, then the optional parity bit, then one stop bit (1).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. In the same cycle the block pops the FIFO and loads the shift register.
  - START → DATA after `CYCLES_PER_BIT` cycles.
  - DATA shifts right every `CYCLES_PER_BIT` cycles. After 8 bits it goes to PARITY if that feature is compiled in, otherwise to STOP.
  - PARITY → STOP after `CYCLES_PER_BIT` cycles.
  - STOP, on its last cycle: if the FIFO is non-empty, pop, load, and go to START, so frames go back-to-back with no idle gap. Otherwise go to IDLE.
- FIFO rules:
  - `ready_out = !full`.
  - A write while full cannot happen, because `ready_out` is low.
  - A pop only happens when the FIFO is non-empty. There is no write-to-pop bypass.
  - Simultaneous write and pop in one cycle is legal and leaves the count unchanged.
- Data captured on a write is unaffected by later changes on `data_in`.

## Timing
- Reset values: `uart_tx_out`=1, `ready_out`=1, `busy_out`=0, FSM in IDLE, FIFO empty, all counters 0.
- Reset applied mid-frame: the line returns to 1 on the cycle after `rst_in` is sampled high. The FIFO contents are discarded and the partial frame is truncated.
- Latency, with the FIFO empty and the FSM in IDLE:
  - Write accepted at edge N.
  - The FIFO reads non-empty from edge N+1, when the block pops and enters START.
  - `uart_tx_out` falls after edge N+2.
- Each line bit is held for exactly `CYCLES_PER_BIT` cycles.
- Frame length is `10*CYCLES_PER_BIT` cycles, or `11*CYCLES_PER_BIT` with parity. At defaults that is 80 (88) cycles.
- `busy_out` drops in the cycle after the last stop-bit cycle when the FIFO is empty.
- `ready_out` reflects the FIFO count registered at the previous edge. It rises in the cycle after a pop that un-fills the FIFO.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the block inserts an even parity bit (XOR of the 8 data bits) after the data bits and enables the PARITY state.
- Undefined: the PARITY state and parity logic are not compiled. Frames are 8N1.

## Structure
- Shared package `uart_pkg` holds:
  - the `uart_tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - the constant `UART_DATA_BITS = 8`;
  - the function `uart_cycles_per_bit(clk_freq, baud)`, which `uart_rx` can reuse.
- Sub-module `uart_tx_fifo`:
  - synchronous FIFO with a `clk_in`/`rst_in` write port, read port, `full`, `empty` and `count`;
  - pointers are one bit wider than the address, for full/empty detection.
- `uart_tx` contains the FSM, the bit counter, the shift register and the output register.

## Test plan
- **Single byte:** write 0xA5 at defaults. Line low for 8 cycles, then bits 1,0,1,0,0,1,0,1 with 8 cycles each, then high for 8 cycles. `busy_out` falls after 80 line cycles.
- **Back-to-back:** write 0x00 then 0xFF in consecutive cycles. Two frames with no idle cycle between the stop bit and the next start bit. Total 160 cycles.
- **Backpressure:** hold `valid_in` high with an incrementing byte from reset.
  - `ready_out` goes low after 17 accepted bytes: 16 stored plus 1 popped.
  - It rises again the cycle after the next pop.
  - The bytes on the line are 0x00…0x10 in order, with none lost or duplicated.
- **Reset mid-frame:** assert `rst_in` during the DATA bit 3 of 0x3C with 4 more bytes queued.
  - `uart_tx_out`=1 and `busy_out`=0 the next cycle, and `ready_out`=1.
  - The line stays high afterwards.
- **Parity (`UART_TX_PARITY_EN` defined):**
  - 0x07 gives parity bit 1.
  - 0x03 gives parity bit 0.
  - The frame is 88 cycles.
- **Loopback:** connect `uart_tx_out` to a `uart_rx` instance with the same `BAUD_RATE`. Send 0x55, 0xC3 and 0x01. The receiver's `valid_out` pulses with matching `byte_out` values.
